// File: rtl/mult_scheduler.sv
// mult_scheduler
//   Sequencer for the shared iterative multiplier of the dual-issue execute
//   stage. Accepts mult/multu from either issue slot, runs a shift-add
//   multiply retiring BITS_PER_CYCLE multiplier bits per cycle, owns HI/LO,
//   and stalls the bundle when it needs the multiplier or HI/LO while a
//   multiply is in flight. Slot 1 is the older instruction, slot 2 the younger.
//
//   Optional feature macro: MULT_HILO_BYPASS_EN
//     defined   : during FIX the read-induced stall is released and Hi/Lo
//                 drive the corrected product combinationally.
//     undefined : stall held through FIX; Hi/Lo are always the registers.
//
//   Ports
//     clk, reset_n                 clock, synchronous active-low reset
//     MultStart/MultStart2         slot 1 / slot 2 multiply request
//     MultSgn/MultSgn2             1 = signed (mult), 0 = unsigned (multu)
//     SrcA/SrcB, SrcA2/SrcB2       slot operands
//     HiRead/LoRead(/2)            slot performs mfhi / mflo
//     Hi, Lo                       HI/LO value to the writeback mux
//     MultStall                    freeze the fetch/decode/execute bundle
//     MultBusy                     multiplier not idle
//     MultDone                     one-cycle pulse after HI/LO update

module mult_scheduler #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             MultStart,
    input  logic             MultStart2,
    input  logic             MultSgn,
    input  logic             MultSgn2,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] SrcA2,
    input  logic [WIDTH-1:0] SrcB2,
    input  logic             HiRead,
    input  logic             LoRead,
    input  logic             HiRead2,
    input  logic             LoRead2,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             MultStall,
    output logic             MultBusy,
    output logic             MultDone
);

    localparam int N_STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int PW      = WIDTH + BITS_PER_CYCLE;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               owned_q, owned_d;
    logic               done_q, done_d;

    logic               start_req;
    logic               any_read;
    logic               read_stall;
    logic               busy;
    logic               accept;
    logic               hazard;
    logic               stall;

    logic               sel_sgn;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic [PW-1:0]              partial;
    logic [PW-1:0]              sum;
    logic [2*WIDTH+BITS_PER_CYCLE-1:0] wide;
    logic [2*WIDTH-1:0]         acc_step;
    logic [2*WIDTH-1:0]         product;

    // Stall and ownership control
    always_comb begin
        // A held bundle whose multiply was already accepted must not restart.
        start_req = (MultStart | MultStart2) & ~owned_q;
        any_read  = HiRead | LoRead | HiRead2 | LoRead2;
        busy      = (state_q != S_IDLE);
        accept    = (state_q == S_IDLE) & start_req;
        // Slot 1 mult followed by a slot 2 read of HI/LO in the same bundle:
        // the younger read must wait for the older multiply.
        hazard    = accept & MultStart & ~MultStart2 & (HiRead2 | LoRead2);
`ifdef MULT_HILO_BYPASS_EN
        // The corrected product is forwarded during FIX, so reads may proceed.
        read_stall = any_read & (state_q != S_FIX);
`else
        read_stall = any_read;
`endif
        stall = (busy & (read_stall | start_req)) | hazard;

        owned_d = owned_q;
        if (accept && stall) begin
            owned_d = 1'b1;
        end else if (!stall) begin
            owned_d = 1'b0;
        end
    end

    // Operand selection: slot 2 wins because its result would overwrite
    // slot 1's in program order anyway.
    always_comb begin
        sel_sgn = MultStart2 ? MultSgn2 : MultSgn;
        sel_a   = MultStart2 ? SrcA2 : SrcA;
        sel_b   = MultStart2 ? SrcB2 : SrcB;
        neg_a   = sel_sgn & sel_a[WIDTH-1];
        neg_b   = sel_sgn & sel_b[WIDTH-1];
        // Negating the most negative value yields 2^(W-1) read as unsigned.
        abs_a   = neg_a ? -sel_a : sel_a;
        abs_b   = neg_b ? -sel_b : sel_b;
    end

    // Shift-add step: add digit*multiplicand to the upper half, then shift
    // the whole accumulator right by one digit. After N_STEPS steps the
    // accumulator holds the full 2W-bit magnitude product.
    always_comb begin
        partial  = PW'(a_q) * PW'(b_q[BITS_PER_CYCLE-1:0]);
        sum      = PW'(acc_q[2*WIDTH-1:WIDTH]) + partial;
        wide     = {sum, acc_q[WIDTH-1:0]};
        acc_step = wide[2*WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
        product  = sign_q ? -acc_q : acc_q;
    end

    // Sequencer
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = abs_a;
                    b_d     = abs_b;
                    sign_d  = sel_sgn & (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                b_d   = b_q >> BITS_PER_CYCLE;
                if (count_q == CNT_W'(N_STEPS - 1)) begin
                    count_d = '0;
                    state_d = S_FIX;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_FIX: begin
                hi_d    = product[2*WIDTH-1:WIDTH];
                lo_d    = product[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            owned_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            owned_q <= owned_d;
            done_q  <= done_d;
        end
    end

`ifdef MULT_HILO_BYPASS_EN
    assign Hi = (state_q == S_FIX) ? product[2*WIDTH-1:WIDTH] : hi_q;
    assign Lo = (state_q == S_FIX) ? product[WIDTH-1:0] : lo_q;
`else
    assign Hi = hi_q;
    assign Lo = lo_q;
`endif

    assign MultStall = stall;
    assign MultBusy  = busy;
    assign MultDone  = done_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Testbench for mult_scheduler (default WIDTH=32, BITS_PER_CYCLE=1).
// Table of single multiplies plus hand-written bundle/stall/reset sequences;
// expected HI/LO pairs go through a scoreboard queue popped on MultDone.

module tb_mult_scheduler;

    localparam int W = 32;
`ifdef MULT_HILO_BYPASS_EN
    localparam int EXP_HAZ_STALL = 33;
`else
    localparam int EXP_HAZ_STALL = 34;
`endif
    localparam int EXP_BUSY = 33;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         MultStart, MultStart2, MultSgn, MultSgn2;
    logic [W-1:0] SrcA, SrcB, SrcA2, SrcB2;
    logic         HiRead, LoRead, HiRead2, LoRead2;
    logic [W-1:0] Hi, Lo;
    logic         MultStall, MultBusy, MultDone;

    always #5 clk = ~clk;

    mult_scheduler dut (
        .clk(clk), .reset_n(reset_n),
        .MultStart(MultStart), .MultStart2(MultStart2),
        .MultSgn(MultSgn), .MultSgn2(MultSgn2),
        .SrcA(SrcA), .SrcB(SrcB), .SrcA2(SrcA2), .SrcB2(SrcB2),
        .HiRead(HiRead), .LoRead(LoRead), .HiRead2(HiRead2), .LoRead2(LoRead2),
        .Hi(Hi), .Lo(Lo),
        .MultStall(MultStall), .MultBusy(MultBusy), .MultDone(MultDone)
    );

    typedef struct {
        logic         slot2;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
        end else begin
            p = {32'b0, a} * {32'b0, b};
        end
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    task automatic clear_inputs();
        MultStart = 0; MultStart2 = 0; MultSgn = 0; MultSgn2 = 0;
        SrcA = '0; SrcB = '0; SrcA2 = '0; SrcB2 = '0;
        HiRead = 0; LoRead = 0; HiRead2 = 0; LoRead2 = 0;
    endtask

    task automatic drive(input logic slot2, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        if (slot2) begin
            MultStart2 = 1; MultSgn2 = sgn; SrcA2 = a; SrcB2 = b;
        end else begin
            MultStart = 1; MultSgn = sgn; SrcA = a; SrcB = b;
        end
    endtask

    // Called at a negedge; waits (bounded) for MultDone, counting busy cycles,
    // then pops the scoreboard and compares HI/LO.
    task automatic wait_done(input string name, output int busy_cnt);
        logic got;
        exp_t e;
        got      = 0;
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (MultDone) begin
                got = 1;
                break;
            end
            if (MultBusy) busy_cnt++;
            @(negedge clk);
        end
        check({name, " done seen"}, 64'(got), 64'd1);
        if (got) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL %s: scoreboard empty at MultDone", name);
            end else begin
                e = sb_q.pop_front();
                check({name, " HI"}, 64'(Hi), 64'(e.hi));
                check({name, " LO"}, 64'(Lo), 64'(e.lo));
            end
        end
    endtask

    // Inputs already driven at the current negedge; expected already pushed.
    task automatic run_one(input string name);
        int bc;
        @(negedge clk);
        clear_inputs();
        wait_done(name, bc);
        check({name, " busy cycles"}, 64'(bc), 64'(EXP_BUSY));
        @(negedge clk);
        check({name, " done pulse"}, 64'(MultDone), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        int   bc;
        exp_t e;
        logic [W-1:0] ra, rb;
        logic rs;

        vecs[0] = '{1'b0, 1'b0, 32'd7,        32'd6,        32'h00000000, 32'h0000002A};
        vecs[1] = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[3] = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[5] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        vecs[6] = '{1'b1, 1'b1, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
        vecs[7] = '{1'b0, 1'b0, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
        vecs[8] = '{1'b0, 1'b1, 32'h00000010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF0};

        // Reset state
        clear_inputs();
        reset_n = 0;
        repeat (2) @(negedge clk);
        check("reset busy",  64'(MultBusy),  64'd0);
        check("reset stall", 64'(MultStall), 64'd0);
        check("reset done",  64'(MultDone),  64'd0);
        check("reset HI",    64'(Hi),        64'd0);
        check("reset LO",    64'(Lo),        64'd0);
        reset_n = 1;
        @(negedge clk);

        // Table of single multiplies
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].slot2, vecs[i].sgn, vecs[i].a, vecs[i].b);
            e.hi = vecs[i].hi;
            e.lo = vecs[i].lo;
            sb_q.push_back(e);
            run_one($sformatf("vec%0d", i));
        end

        // Random operands against the reference model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            drive(1'(i & 1), rs, ra, rb);
            sb_q.push_back(model(rs, ra, rb));
            run_one($sformatf("rand%0d", i));
        end

        // Bundle {slot 1 mult 2x3, slot 2 mflo} held under stall
        MultStart = 1; MultSgn = 1; SrcA = 32'd2; SrcB = 32'd3; LoRead2 = 1;
        e.hi = 0; e.lo = 32'd6;
        sb_q.push_back(e);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!MultStall) break;
            cnt++;
            @(negedge clk);
        end
        check("hazard stall cycles", 64'(cnt), 64'(EXP_HAZ_STALL));
        e = sb_q.pop_front();
        check("hazard slot2 LO", 64'(Lo), 64'(e.lo));
        @(negedge clk);
        clear_inputs();
        #1;
        check("hazard no restart", 64'(MultBusy), 64'd0);
        @(negedge clk);
        check("hazard idle", 64'(MultBusy), 64'd0);
        check("hazard HI reg", 64'(Hi), 64'd0);
        check("hazard LO reg", 64'(Lo), 64'd6);

        // Bundle with both slots multu: slot 2 wins, single run
        MultStart = 1; MultSgn = 0; SrcA = 32'd2; SrcB = 32'd2;
        MultStart2 = 1; MultSgn2 = 0; SrcA2 = 32'd5; SrcB2 = 32'd5;
        #1;
        check("dual start no stall", 64'(MultStall), 64'd0);
        e.hi = 0; e.lo = 32'd25;
        sb_q.push_back(e);
        run_one("dual");

        // New multiply while busy: stalled, accepted in first IDLE cycle
        drive(1'b0, 1'b0, 32'd3, 32'd3);
        e.hi = 0; e.lo = 32'd9;
        sb_q.push_back(e);
        @(negedge clk);
        clear_inputs();
        repeat (5) @(negedge clk);
        drive(1'b0, 1'b0, 32'd10, 32'd10);
        #1;
        check("busy start stall", 64'(MultStall), 64'd1);
        for (int i = 0; i < 200; i++) begin
            if (!MultStall) break;
            @(negedge clk);
            #1;
        end
        check("busy start release on done", 64'(MultDone), 64'd1);
        e = sb_q.pop_front();
        check("first of pair LO", 64'(Lo), 64'(e.lo));
        e.hi = 0; e.lo = 32'd100;
        sb_q.push_back(e);
        @(negedge clk);
        clear_inputs();
        check("queued start accepted", 64'(MultBusy), 64'd1);
        wait_done("second of pair", bc);
        check("second of pair busy", 64'(bc), 64'(EXP_BUSY));
        @(negedge clk);

        // Slot 1 mfhi with slot 2 mult: no stall, old HI visible
        drive(1'b0, 1'b0, 32'h11000000, 32'h00000100);
        e.hi = 32'h11; e.lo = 0;
        sb_q.push_back(e);
        run_one("prime HI");
        HiRead = 1;
        drive(1'b1, 1'b1, 32'd4, 32'd4);
        #1;
        check("mfhi slot1 no stall", 64'(MultStall), 64'd0);
        check("mfhi slot1 old HI", 64'(Hi), 64'h11);
        e.hi = 0; e.lo = 32'd16;
        sb_q.push_back(e);
        run_one("mfhi+mult");

        // Reset in the middle of RUN
        drive(1'b0, 1'b0, 32'h1234, 32'h5678);
        @(negedge clk);
        clear_inputs();
        repeat (9) @(negedge clk);
        check("pre-reset busy", 64'(MultBusy), 64'd1);
        reset_n = 0;
        HiRead  = 1;
        @(negedge clk);
        check("mid-run reset busy",  64'(MultBusy),  64'd0);
        check("mid-run reset stall", 64'(MultStall), 64'd0);
        check("mid-run reset HI",    64'(Hi),        64'd0);
        check("mid-run reset LO",    64'(Lo),        64'd0);
        reset_n = 1;
        HiRead  = 0;
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd9, 32'd9);
        e.hi = 0; e.lo = 32'd81;
        sb_q.push_back(e);
        run_one("post-reset 9x9");

        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Sequencer for the shared iterative multiplier in the dual-issue execute stage. Accepts `mult`/`multu` requests from either issue slot, runs a shift-add multiply over WIDTH/BITS_PER_CYCLE cycles, and owns the HI/LO registers. Generates a pipeline stall when a bundle needs the multiplier or HI/LO while a multiply is in flight, preserving program order between slot 1 (older) and slot 2 (younger).

## Interface
- WIDTH, 32, operand width; HI/LO each WIDTH bits
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4

- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- MultStart, MultStart2  in  1  slot 1 / slot 2 multiply request (from decode)
- MultSgn, MultSgn2  in  1  1 = signed (`mult`), 0 = unsigned (`multu`)
- SrcA, SrcB, SrcA2, SrcB2  in  WIDTH  slot operands
- HiRead, LoRead, HiRead2, LoRead2  in  1  slot performs `mfhi`/`mflo` (WBSrc 10/11)
- Hi, Lo  out  WIDTH  HI/LO value presented to writeback mux
- MultStall  out  1  freeze fetch/decode/execute bundle
- MultBusy  out  1  state != IDLE
- MultDone  out  1  one-cycle pulse, HI/LO just updated

## Operation
- States: IDLE, RUN, FIX.
- IDLE, accepted start (see ownership rule): capture operands, go RUN, count=0.
  - Only slot 1 requests: capture slot 1.
  - Slot 2 requests (with or without slot 1): capture slot 2. Slot 1's result would be overwritten in program order, so it is discarded.
- Capture: sign = MultSgn & (a[W-1]^b[W-1]); store |a|, |b| when signed, raw otherwise. |−2^(W-1)| = 2^(W-1) unsigned.
- RUN: retire BITS_PER_CYCLE multiplier bits per cycle into a 2W-bit accumulator. After WIDTH/BITS_PER_CYCLE cycles go FIX.
- FIX: product = sign ? −acc : acc (2W-bit two's complement). HI<=product[2W-1:W], LO<=product[W-1:0] at the end of FIX, then IDLE with MultDone=1 for the following cycle.
- Ownership flag `owned`:
  - Set when a start is accepted in a cycle where MultStall=1.
  - While set, MultStart/MultStart2 are ignored, so a held bundle never restarts.
  - Cleared on the first cycle with MultStall=0.
- MultStall = MultBusy & (any Hi/LoRead | any MultStart not masked by `owned`), plus bundle hazard in IDLE: slot 1 start accepted and (HiRead2|LoRead2) → stall from the accept cycle.
- Slot 1 read with slot 2 mult in IDLE: no stall; slot 1 sees old HI/LO (update occurs only at FIX).
- New mult while busy: stalled, accepted in the first IDLE cycle; no queue.
- Hi/Lo outputs = HI/LO registers (bypass exception under Configuration).

## Timing
- Reset (reset_n=0 at edge): state=IDLE, HI=LO=0, acc=0, count=0, owned=0, MultStall=0, MultBusy=0, MultDone=0. Reset mid-RUN/FIX aborts; HI/LO cleared, never partially written.
- Accept at edge E0; RUN occupies N=WIDTH/BITS_PER_CYCLE cycles; FIX one cycle; HI/LO valid from edge E(N+1) (default E33).
- MultStall is combinational from the same-cycle inputs and state.
- MultStall drops in the first IDLE cycle after FIX (no bypass); the held read sees the new HI/LO that cycle.
- Counter wraps to 0 on FIX entry; no other wrap.

## Configuration
- MULT_HILO_BYPASS_EN defined: in FIX, read-induced stall is released and Hi/Lo drive the corrected product combinationally; pending start still stalls until IDLE. Saves one cycle per dependent read.
- Undefined: stall held through FIX; Hi/Lo always registered values.

## Test plan
- `multu` 7×6 in slot 1, IDLE → MultBusy 33 cycles, MultDone pulse, HI=0x00000000, LO=0x0000002A.
- `mult` −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; `multu` 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `mult` 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- Bundle {slot 1 `mult` 2×3, slot 2 `mflo`} held under stall → exactly one multiply, stall 34 cycles (33 with bypass), slot 2 reads LO=6.
- Bundle {slot 1 `multu` 2×2, slot 2 `multu` 5×5} → single run, HI=0, LO=25.
- `mfhi` in slot 1 with slot 2 `mult` 4×4 and prior HI=0x11 → no stall, slot 1 reads 0x11; HI=0 after completion.
- reset_n low at cycle 10 of RUN → next cycle IDLE, HI=LO=0, MultStall=0; fresh `multu` 9×9 then yields LO=81.
